// File: rtl/timer_pkg.sv
// Shared definitions for the timer datapath and its requester arbiter.
package timer_pkg;
  localparam int TMR_DW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    WAIT  = 2'd3
  } tmr_state_e;
endpackage

// File: rtl/timer_arbiter_if.sv
// Requester/timer-side bundle of the shared-timer arbiter.
interface timer_arbiter_if import timer_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW   = TMR_DW
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] delay;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               tmr_load;
  logic [DW-1:0]      tmr_delay;
  logic               tmr_count_ena;
  logic               tmr_done_counting;

  modport master (
    output req, delay, ack, tmr_done_counting,
    input  gnt, done, busy, tmr_load, tmr_delay, tmr_count_ena
  );

  modport slave (
    input  req, delay, ack, tmr_done_counting,
    output gnt, done, busy, tmr_load, tmr_delay, tmr_count_ena
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set req at or above ptr, wrapping.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            any
);
  int j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one countdown timer among NREQ requesters.
module timer_arbiter import timer_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW   = TMR_DW
) (
  input logic            clk,
  input logic            reset,
  timer_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  tmr_state_e      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [DW-1:0]   dly_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q, load_q, cena_q;

  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            any;
  logic [IW-1:0]   ptr_nxt;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign ptr_nxt = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);

  // Every output is a flop so nothing combinational reaches the requesters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gidx   <= '0;
      dly_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
      load_q <= 1'b0;
      cena_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state  <= LOAD;
          gnt_q  <= win;
          gidx   <= win_idx;
          dly_q  <= bus.delay[int'(win_idx)*DW +: DW];
          ptr    <= ptr_nxt;
          busy_q <= 1'b1;
          load_q <= 1'b1;
        end
        LOAD: begin
          state  <= COUNT;
          load_q <= 1'b0;
          cena_q <= 1'b1;
        end
        COUNT: if (bus.tmr_done_counting) begin
          state  <= WAIT;
          cena_q <= 1'b0;
          done_q <= gnt_q;
        end
        WAIT: if (bus.ack[gidx]) begin
          state  <= IDLE;
          gnt_q  <= '0;
          done_q <= '0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.tmr_load      = load_q;
  assign bus.tmr_delay     = dly_q;
  assign bus.tmr_count_ena = cena_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// Directed vector bench for timer_arbiter (NREQ=4, DW=4).
module tb_timer_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_arbiter_if #(.NREQ(4), .DW(4)) bus ();
  timer_arbiter #(.NREQ(4), .DW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] dly;
    logic [3:0]  ack;
    logic        tdc;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        load;
    logic        cena;
    logic [3:0]  tdel;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic l, input logic c, input logic [3:0] t);
    chk({tag, ".gnt"},       16'(bus.gnt), 16'(g));
    chk({tag, ".done"},      16'(bus.done), 16'(d));
    chk({tag, ".busy"},      16'(bus.busy), 16'(b));
    chk({tag, ".tmr_load"},  16'(bus.tmr_load), 16'(l));
    chk({tag, ".count_ena"}, 16'(bus.tmr_count_ena), 16'(c));
    chk({tag, ".tmr_delay"}, 16'(bus.tmr_delay), 16'(t));
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] ak, input logic td);
    reset = r; bus.req = rq; bus.ack = ak; bus.tmr_done_counting = td;
    @(posedge clk); #1;
  endtask

  // One prompt transaction: IDLE->LOAD, ->COUNT, done ->WAIT, ack ->IDLE.
  task automatic add_txn(input logic [3:0] rq, input logic [3:0] g, input logic [3:0] d);
    vq.push_back('{1'b0, rq, 16'h4321, 4'h0, 1'b0, g, 4'h0, 1'b1, 1'b1, 1'b0, d});
    vq.push_back('{1'b0, rq, 16'h4321, 4'h0, 1'b0, g, 4'h0, 1'b1, 1'b0, 1'b1, d});
    vq.push_back('{1'b0, rq, 16'h4321, 4'h0, 1'b1, g, g,    1'b1, 1'b0, 1'b0, d});
    vq.push_back('{1'b0, rq, 16'h4321, g,    1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, d});
  endtask

  initial begin
    reset = 1'b1; bus.req = '0; bus.ack = '0; bus.delay = '0; bus.tmr_done_counting = 1'b0;

    // Single requester with delay 5, plus ignored-input checks.
    vq.push_back('{1, 4'h0, 16'h0005, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0});
    vq.push_back('{1, 4'h0, 16'h0005, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0});
    vq.push_back('{0, 4'h0, 16'h0005, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0});
    vq.push_back('{0, 4'h1, 16'h0005, 4'h0, 0, 4'h1, 4'h0, 1, 1, 0, 4'h5});
    vq.push_back('{0, 4'h1, 16'h0005, 4'h0, 1, 4'h1, 4'h0, 1, 0, 1, 4'h5}); // tdc in LOAD ignored
    vq.push_back('{0, 4'h1, 16'h0005, 4'h0, 0, 4'h1, 4'h0, 1, 0, 1, 4'h5});
    vq.push_back('{0, 4'h1, 16'h0005, 4'h1, 0, 4'h1, 4'h0, 1, 0, 1, 4'h5}); // early ack ignored
    vq.push_back('{0, 4'h1, 16'h0005, 4'h0, 1, 4'h1, 4'h1, 1, 0, 0, 4'h5});
    vq.push_back('{0, 4'h1, 16'h0005, 4'h2, 0, 4'h1, 4'h1, 1, 0, 0, 4'h5}); // foreign ack ignored
    vq.push_back('{0, 4'h1, 16'h0005, 4'h0, 0, 4'h1, 4'h1, 1, 0, 0, 4'h5}); // early ack not remembered
    vq.push_back('{0, 4'h0, 16'h0005, 4'h1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h5});
    vq.push_back('{1, 4'h0, 16'h0005, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0});
    vq.push_back('{0, 4'h0, 16'h4321, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0});
    // Round-robin with all requesting, then skip to 2 and wrap from ptr=3 to 0.
    add_txn(4'hF, 4'h1, 4'h1);
    add_txn(4'hF, 4'h2, 4'h2);
    add_txn(4'hF, 4'h4, 4'h3);
    add_txn(4'hF, 4'h8, 4'h4);
    add_txn(4'hF, 4'h1, 4'h1);
    add_txn(4'h4, 4'h4, 4'h3);
    add_txn(4'h3, 4'h1, 4'h1);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      bus.delay = vq[i].dly;
      step(vq[i].rst, vq[i].req, vq[i].ack, vq[i].tdc);
      chk_all($sformatf("vec%0d", i), vq[i].gnt, vq[i].done, vq[i].busy,
              vq[i].load, vq[i].cena, vq[i].tdel);
    end

    // Delay change and dropped req mid-count; ptr is 1 here so req0 wins after wrapping.
    bus.delay = 16'h4321;
    step(0, 4'h1, 4'h0, 0); chk_all("ab_load", 4'h1, 4'h0, 1, 1, 0, 4'h1);
    step(0, 4'h1, 4'h0, 0); chk_all("ab_count", 4'h1, 4'h0, 1, 0, 1, 4'h1);
    bus.delay = 16'h432F;
    step(0, 4'h0, 4'h0, 0); chk_all("ab_dlychg", 4'h1, 4'h0, 1, 0, 1, 4'h1);
    step(0, 4'h0, 4'h0, 1); chk_all("ab_wait", 4'h1, 4'h1, 1, 0, 0, 4'h1);
    step(0, 4'h0, 4'h0, 0); chk_all("ab_hold1", 4'h1, 4'h1, 1, 0, 0, 4'h1);
    step(0, 4'h0, 4'h2, 0); chk_all("ab_hold2", 4'h1, 4'h1, 1, 0, 0, 4'h1);
    step(0, 4'h0, 4'h1, 0); chk_all("ab_idle", 4'h0, 4'h0, 0, 0, 0, 4'h1);

    // Reset held two cycles during COUNT, then grant must restart from requester 0.
    step(0, 4'h2, 4'h0, 0); chk_all("rst_load", 4'h2, 4'h0, 1, 1, 0, 4'h2);
    step(0, 4'h2, 4'h0, 0); chk_all("rst_count", 4'h2, 4'h0, 1, 0, 1, 4'h2);
    step(1, 4'h2, 4'h0, 0); chk_all("rst_c1", 4'h0, 4'h0, 0, 0, 0, 4'h0);
    step(1, 4'hF, 4'h0, 1); chk_all("rst_c2", 4'h0, 4'h0, 0, 0, 0, 4'h0);
    bus.delay = 16'h4327;
    step(0, 4'hF, 4'h0, 0); chk_all("rst_regnt", 4'h1, 4'h0, 1, 1, 0, 4'h7);
    step(0, 4'hF, 4'h0, 0); chk_all("rst_cnt2", 4'h1, 4'h0, 1, 0, 1, 4'h7);
    step(0, 4'hF, 4'h0, 1); chk_all("rst_wait", 4'h1, 4'h1, 1, 0, 0, 4'h7);
    step(0, 4'h0, 4'h1, 0); chk_all("rst_idle", 4'h0, 4'h0, 0, 0, 0, 4'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares one programmable countdown timer datapath among `NREQ` requesters. Each requester presents a delay value and a request; the arbiter grants round-robin and loads the winner's delay into the timer. It then enables counting, reports completion back to the winner, and waits for that requester's acknowledge before serving the next request. It sits between the pattern-triggered front ends and the shared timer counter.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `DW`, default 4: delay field width; must match the timer datapath.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high; clock `clk`.
- `req`, in, `NREQ`: per-requester request level.
- `delay`, in, `NREQ*DW`: requester i's delay is at bits `[i*DW +: DW]`.
- `ack`, in, `NREQ`: per-requester acknowledge of `done`.
- `gnt`, out, `NREQ`: one-hot grant, held for the whole transaction.
- `done`, out, `NREQ`: one-hot completion indication to the granted requester.
- `busy`, out, 1: high in any state other than IDLE.
- `tmr_load`, out, 1: one-cycle load strobe to the timer.
- `tmr_delay`, out, `DW`: delay value presented with `tmr_load`.
- `tmr_count_ena`, out, 1: timer count enable.
- `tmr_done_counting`, in, 1: timer reached terminal count.

## Operation
- States and transitions:
  - IDLE → LOAD when `|req`. Winner is the first set `req` bit searched upward from `ptr`, wrapping modulo `NREQ`.
  - On that transition: register `gnt`, latch the winner's delay into `dly_q`, and set `ptr` = (winner+1) mod `NREQ`.
  - LOAD → COUNT unconditionally.
  - COUNT → WAIT when `tmr_done_counting` is 1; otherwise stay in COUNT.
  - WAIT → IDLE when `ack` bit of the granted index is 1; `gnt` clears on that transition.
- Outputs by state:
  - `tmr_load` = 1 only in LOAD; `tmr_delay` = `dly_q` at all times.
  - `tmr_count_ena` = 1 only in COUNT.
  - `done` = `gnt` in WAIT, 0 elsewhere.
  - `gnt` is nonzero exactly in LOAD, COUNT and WAIT.
- The delay value is captured at grant; later changes to `delay` do not affect the transaction in progress.
- A requester dropping `req` mid-transaction does not abort it; the transaction always completes through WAIT.
- `ack` bits of non-granted requesters are ignored in every state. The granted requester's `ack` outside WAIT is ignored and is not remembered.
- `tmr_done_counting` outside COUNT is ignored. If it is high in the first COUNT cycle, the FSM moves to WAIT on the next edge.
- Reset (any state, including mid-count): state IDLE, `ptr` 0, `dly_q` 0, and all outputs 0 on the next edge. The timer is not explicitly cleared; it stalls because `tmr_count_ena` drops.

## Timing
- `req` sampled high in IDLE at edge t gives `gnt` and `tmr_load` high during cycle t+1.
- `tmr_count_ena` is high from cycle t+2.
- `tmr_done_counting` sampled at edge u gives `done` high from cycle u+1.
- `ack` sampled in WAIT at edge v gives IDLE in cycle v+1. The earliest next grant is cycle v+2, so there is at least one IDLE bubble between transactions.
- All outputs are registered or decoded from the registered state. There are no combinational paths from inputs to outputs.
- Worst-case wait for a continuously requesting agent is `NREQ`-1 full transactions.

## Structure
- Shared package `timer_pkg` holds:
  - The state encoding constants IDLE, LOAD, COUNT, WAIT (2 bits).
  - Default `DW`, so the timer datapath and the arbiter agree on width.
- Sub-module `rr_picker`: purely combinational.
  - Inputs: `req` and `ptr`.
  - Outputs: one-hot `win` and its binary index `win_idx`, plus `any`.
  - Instantiated once; separately testable.

## Test plan
- Reset: assert `reset` for 2 cycles during COUNT → `gnt`, `done`, `tmr_load`, `tmr_count_ena` and `busy` are all 0 on the next cycle, and the first subsequent grant goes to requester 0.
- Single requester: `req`=0001 with delay 5 → `tmr_load` high for one cycle with `tmr_delay`=5. Then `tmr_count_ena` stays high until `tmr_done_counting`, after which `done`=0001 is held until `ack[0]`.
- Round-robin: `req`=1111 held high, `ack` issued promptly each time → grant order 0001, 0010, 0100, 1000, 0001.
- Skip and wrap: after serving requester 2, `req`=0011 → next grant 0001. This checks that the search wraps from `ptr`=3.
- Ignored inputs:
  - `ack[1]` while requester 0 is in WAIT → no transition.
  - `tmr_done_counting` pulsed in LOAD → FSM still enters COUNT.
  - `delay[0]` changed during COUNT → `tmr_delay` unchanged.
- Abandoned request: `req[0]` dropped during COUNT → transaction still reaches WAIT and needs `ack[0]` to return to IDLE.
